// File: rtl/tristate_bus_rx_pkg.sv
// Shared types and defaults for the three-state bus receiver.
package tristate_bus_pkg;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_t;

   localparam int DEF_DATA_W      = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = $clog2(DEF_DATA_W + 1);

   // Width needed to hold a bit count of 0..w inclusive.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/tristate_bus_rx_if.sv
// Line, enable and word-handshake signals between the shared bus and the receiver.
interface tristate_bus_rx_if
   import tristate_bus_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);

   logic              bus_en_n;
   logic              bus_d;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              abort;
   logic              overrun;
   logic              overrun_clr;
   logic              busy;

   modport master (
      output bus_en_n, bus_d, out_ready, overrun_clr,
      input  out_data, out_valid, abort, overrun, busy
   );

   modport slave (
      input  bus_en_n, bus_d, out_ready, overrun_clr,
      output out_data, out_valid, abort, overrun, busy
   );

endinterface

// File: rtl/tristate_bus_rx_bit_sync.sv
// Single-bit flop-chain synchroniser with a selectable reset value.
module bit_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= {STAGES{RST_VAL}};
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/tristate_bus_rx.sv
// Samples the shared line, deserialises driven bits into words and offers them
// on a valid/ready handshake, flagging aborted frames and overruns.
//
// state    | meaning
// RX_IDLE  | line not driven; waiting for a sampled low enable
// RX_SHIFT | enable low; shifting bits, words complete every DATA_W bits
module tristate_bus_rx
   import tristate_bus_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   tristate_bus_rx_if.slave bus
);

   localparam int CNT_W = cnt_width(DATA_W);

   rx_state_t         r_state, w_state;
   logic [CNT_W-1:0]  r_count, w_count;
   logic [DATA_W-1:0] r_shift, w_shift;
   logic [DATA_W-1:0] r_data,  w_data;
   logic              r_valid, w_valid;
   logic              r_abort, w_abort;
   logic              r_overrun, w_overrun;

   logic              w_en_s;
   logic              w_d_s;
   logic              w_done;
   logic [DATA_W-1:0] w_word;

   bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_en (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.bus_en_n),
      .o_q   (w_en_s)
   );

   bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_d (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.bus_d),
      .o_q   (w_d_s)
   );

   // First-received bit ends up in the MSB after DATA_W shifts.
   assign w_word = {r_shift[DATA_W-2:0], w_d_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= RX_IDLE;
         r_count   <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_abort   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_count   <= w_count;
         r_shift   <= w_shift;
         r_data    <= w_data;
         r_valid   <= w_valid;
         r_abort   <= w_abort;
         r_overrun <= w_overrun;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_count   = r_count;
      w_shift   = r_shift;
      w_data    = r_data;
      w_valid   = r_valid;
      w_abort   = 1'b0;
      w_overrun = r_overrun;
      w_done    = 1'b0;

      if (bus.overrun_clr) begin
         w_overrun = 1'b0;
      end
      if (r_valid && bus.out_ready) begin
         w_valid = 1'b0;
      end

      case (r_state)
         RX_IDLE: begin
            if (!w_en_s) begin
               w_state = RX_SHIFT;
               w_shift = w_word;
               w_count = CNT_W'(1);
            end
         end
         RX_SHIFT: begin
            if (!w_en_s) begin
               w_shift = w_word;
               if (r_count == CNT_W'(DATA_W - 1)) begin
                  w_count = '0;
                  w_done  = 1'b1;
               end else begin
                  w_count = r_count + CNT_W'(1);
               end
            end else begin
               w_state = RX_IDLE;
               w_abort = (r_count != '0);
               w_count = '0;
               w_shift = '0;
            end
         end
         default: begin
            w_state = RX_IDLE;
         end
      endcase

      // A completing word either replaces the accepted one or is dropped.
      if (w_done) begin
         if (!r_valid || bus.out_ready) begin
            w_data  = w_word;
            w_valid = 1'b1;
         end else begin
            w_overrun = 1'b1;
         end
      end
   end

   assign bus.out_data  = r_data;
   assign bus.out_valid = r_valid;
   assign bus.abort     = r_abort;
   assign bus.overrun   = r_overrun;
   assign bus.busy      = (r_state == RX_SHIFT);

endmodule

// File: doc/tristate_bus_rx.md
Name: tristate_bus_rx

Overview:
- Receive-side companion to the team's three-state line driver: the driver owns a shared single-bit line while its active-low enable is low and floats the line otherwise.
- This block samples the shared line and the driver's enable into its own clock domain, deserialises driven bits into DATA_W-bit words, and presents each word on a valid/ready handshake.
- It flags aborted frames (enable released mid-word) and overruns (a word completes while the previous one is unconsumed).
- The line has an external pull-up, so an undriven line reads 1.

Parameters:
- DATA_W, 8, bits per word; legal range 2..32.
- SYNC_STAGES, 2, flops in each input synchroniser; legal range 2..3.

Ports:
- clk  input  1  block clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus_en_n  input  1  remote driver enable; low means the driver is driving the line. Asynchronous.
- bus_d  input  1  shared line value; reads 1 when floated. Asynchronous.
- out_data  output  DATA_W  received word, first-received bit in the MSB.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- abort  output  1  one-cycle pulse: frame ended with a partial word.
- overrun  output  1  sticky: a word was dropped because out_valid was still high.
- overrun_clr  input  1  synchronous clear of overrun.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (async assert, sync deassert by the integrator): all sync flops 1, state IDLE, bit count 0, shift register 0, out_data 0, out_valid 0, abort 0, overrun 0, busy 0.
- Synchroniser: bus_en_n and bus_d each pass through SYNC_STAGES flops; en_s and d_s denote the outputs. All logic below uses only en_s and d_s.
- States: IDLE and SHIFT. busy = (state == SHIFT).
- IDLE -> SHIFT: on en_s == 0. The same cycle samples d_s as bit 0 of the word and sets count = 1.
- In SHIFT with en_s == 0:
  - shift d_s into the LSB; count increments.
  - When count reaches DATA_W, the word is complete: count returns to 0 and the state stays SHIFT.
  - Back-to-back words within one enable window are allowed.
- In SHIFT with en_s == 1:
  - go to IDLE.
  - If count != 0, pulse abort for exactly one cycle, discard the partial word, and set count to 0.
  - If count == 0, no abort.
- Word completion (the cycle the DATA_W-th bit is shifted):
  - If out_valid == 0, or out_valid && out_ready in the same cycle: load out_data with the full word and set out_valid = 1 on the next edge.
  - Otherwise keep the old out_data, drop the new word, and set overrun.
- Latency: bus_d edge to out_valid = SYNC_STAGES + DATA_W cycles, with enable already low.
- out_valid clears on out_valid && out_ready when no completion occurs that cycle. out_data is stable while out_valid is high.
- overrun: overrun_clr clears it. If overrun_clr and a new overrun occur in the same cycle, set wins.
- Single-cycle enable glitches shorter than one clock may be missed; this is acceptable by design. Any sampled low enable counts as a frame start.
- Reset asserted mid-frame: immediate return to reset values, no abort pulse.

Decomposition:
- Shared package tristate_bus_pkg:
  - state enum rx_state_t {RX_IDLE, RX_SHIFT};
  - default DATA_W and SYNC_STAGES constants;
  - helper localparam for the count width, $clog2(DATA_W+1).
- One sub-module: bit_sync, a parameterised SYNC_STAGES flop chain with a reset value parameter. It is instantiated twice, for bus_en_n and bus_d, both with reset value 1.

Test Plan:
- Single word: drive en_n=0 and bits 1,0,1,0,0,1,0,1 for 8 cycles, then en_n=1, out_ready=1 -> out_valid high at cycle 2+8; out_data=8'hA5; no abort.
- Back-to-back: hold en_n low for 16 bits 8'h3C then 8'hC3, out_ready=1 -> two valid beats, 3C then C3, 8 cycles apart; busy high throughout.
- Abort: en_n low for 5 bits, then high -> abort pulses once, about 2 cycles after the en_n rise; out_valid stays 0; the next full frame 8'h81 is received correctly.
- Overrun: out_ready=0; send 8'h11 then 8'h22 -> out_data stays 11, overrun=1. Pulse overrun_clr -> overrun=0. Raise out_ready -> 11 accepted, out_valid falls.
- Accept/complete same cycle: raise out_ready on exactly the completion cycle of the second word -> no overrun; out_data=second word.
- Floated line: en_n=1, bus_d=1 for 50 cycles -> busy=0, out_valid=0. Assert rst_n=0 mid-frame at bit 4 -> all outputs zero with no abort pulse.
